// File: rtl/mux_tree_cfg_chain.sv
// N_CH-channel routing mux tree fed by a serial shadow configuration chain with atomic commit.
// Define MUX_TREE_CFG_OUT_REG_EN to register the channel outputs on prog_clk.
module mux_tree_cfg_chain #(
  parameter int N_IN = 14,
  parameter int N_CH = 2
) (
  input  logic            prog_clk,
  input  logic            pReset,
  input  logic [N_IN-1:0] in,
  input  logic            ccff_head,
  input  logic            cfg_en,
  input  logic            cfg_commit,
  output logic            ccff_tail,
  output logic            cfg_full,
  output logic            cfg_err,
  output logic [N_CH-1:0] out
);
  localparam int SEL_W  = $clog2(N_IN + 1);
  localparam int TOT    = N_CH * SEL_W;
  localparam int CNT_W  = $clog2(TOT + 1);
  localparam int LEAVES = 2 ** SEL_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOADING,
    ST_FULL
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [TOT-1:0]   chain_reg;
  logic [TOT-1:0]   active_reg;
  logic             cfg_err_reg;
  logic             commit_ok;

  assign commit_ok = cfg_commit && (state_reg == ST_FULL);

  // Shadow chain, load counter FSM and active select share one register block.
  // A commit snapshots the chain as it stood before this edge, so a shift in
  // the same cycle counts toward the next load.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_reg   <= ST_EMPTY;
      cnt_reg     <= '0;
      chain_reg   <= '0;
      active_reg  <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_commit && (state_reg != ST_FULL);
      if (cfg_en) begin
        chain_reg <= {chain_reg[TOT-2:0], ccff_head};
      end
      if (commit_ok) begin
        active_reg <= chain_reg;
        if (cfg_en) begin
          cnt_reg   <= CNT_ONE;
          state_reg <= ST_LOADING;
        end else begin
          cnt_reg   <= '0;
          state_reg <= ST_EMPTY;
        end
      end else if (cfg_en && (state_reg != ST_FULL)) begin
        cnt_reg   <= cnt_reg + 1'b1;
        state_reg <= (cnt_reg == CNT_LAST) ? ST_FULL : ST_LOADING;
      end
    end
  end

  assign ccff_tail = chain_reg[TOT-1];
  assign cfg_full  = (state_reg == ST_FULL);
  assign cfg_err   = cfg_err_reg;

  // Leaves above N_IN-1 are the constant-1 leaves; an all-zero active word
  // decodes to the top leaf, so every channel idles at 1.
  logic [LEAVES-1:0] leaf_vec;
  logic [N_CH-1:0]   out_comb;

  assign leaf_vec = {{(LEAVES - N_IN){1'b1}}, in};

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SEL_W-1:0] idx;
      assign idx          = ~active_reg[gi*SEL_W +: SEL_W];
      assign out_comb[gi] = leaf_vec[idx];
    end
  endgenerate

`ifdef MUX_TREE_CFG_OUT_REG_EN
  logic [N_CH-1:0] out_reg;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      out_reg <= '1;
    end else begin
      out_reg <= out_comb;
    end
  end

  assign out = out_reg;
`else
  assign out = out_comb;
`endif

endmodule

// File: tb/tb_mux_tree_cfg_chain.sv
// Scoreboard bench for mux_tree_cfg_chain: directed scenarios plus randomized
// shift/commit traffic, checked against a behavioural model of the config rules.
module tb_mux_tree_cfg_chain;
  localparam int N_IN  = 14;
  localparam int N_CH  = 2;
  localparam int SEL_W = $clog2(N_IN + 1);
  localparam int TOT   = N_CH * SEL_W;

  logic            prog_clk = 1'b0;
  logic            pReset = 1'b0;
  logic [N_IN-1:0] in = '0;
  logic            ccff_head = 1'b0;
  logic            cfg_en = 1'b0;
  logic            cfg_commit = 1'b0;
  logic            ccff_tail;
  logic            cfg_full;
  logic            cfg_err;
  logic [N_CH-1:0] out;

  mux_tree_cfg_chain #(.N_IN(N_IN), .N_CH(N_CH)) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .in        (in),
    .ccff_head (ccff_head),
    .cfg_en    (cfg_en),
    .cfg_commit(cfg_commit),
    .ccff_tail (ccff_tail),
    .cfg_full  (cfg_full),
    .cfg_err   (cfg_err),
    .out       (out)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct packed {
    logic [N_CH-1:0] out;
    logic            full;
    logic            err;
    logic            tail;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_vec = 0;
  int   n_bad = 0;

  // Behavioural model: shifted bits, committed select word, load count.
  logic [TOT-1:0] chain_m;
  logic [TOT-1:0] active_m;
  int             cnt_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h at %0t", name, act, $time);
    end
  endtask

  // Channel c reads its select bits, inverts them to a leaf number, and
  // returns that input or constant 1 for leaves past the last input.
  function automatic logic [N_CH-1:0] decode(input logic [TOT-1:0] act, input logic [N_IN-1:0] d);
    logic [N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) begin
      int leaf;
      leaf = 0;
      for (int j = 0; j < SEL_W; j++) begin
        if (act[c*SEL_W + j] == 1'b0) leaf += (1 << j);
      end
      r[c] = (leaf < N_IN) ? d[leaf] : 1'b1;
    end
    return r;
  endfunction

  task automatic step(input logic en, input logic head, input logic commit, input logic [N_IN-1:0] din);
    exp_t           e;
    logic [TOT-1:0] act_before;
    @(negedge prog_clk);
    cfg_en     = en;
    ccff_head  = head;
    cfg_commit = commit;
    in         = din;
    act_before = active_m;
    e.err      = commit && (cnt_m != TOT);
    if (commit && cnt_m == TOT) begin
      active_m = chain_m;
      cnt_m    = en ? 1 : 0;
    end else if (en && cnt_m < TOT) begin
      cnt_m = cnt_m + 1;
    end
    if (en) chain_m = {chain_m[TOT-2:0], head};
`ifdef MUX_TREE_CFG_OUT_REG_EN
    e.out = decode(act_before, din);
`else
    e.out = decode(active_m, din);
`endif
    e.full = (cnt_m == TOT);
    e.tail = chain_m[TOT-1];
    q.push_back(e);
  endtask

  task automatic idle(input logic [N_IN-1:0] din);
    step(1'b0, 1'b0, 1'b0, din);
  endtask

  task automatic load(input logic [TOT-1:0] word, input int nbits);
    for (int i = TOT - 1; i > TOT - 1 - nbits; i--) begin
      step(1'b1, word[i], 1'b0, N_IN'($urandom));
    end
  endtask

  task automatic settle();
    @(posedge prog_clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge prog_clk);
    pReset     = 1'b0;
    cfg_en     = 1'b0;
    cfg_commit = 1'b0;
    chain_m    = '0;
    active_m   = '0;
    cnt_m      = 0;
    #1;
    chk("rst_out", 32'(out), 32'(3));
    chk("rst_full", 32'(cfg_full), 32'(0));
    chk("rst_err", 32'(cfg_err), 32'(0));
    chk("rst_tail", 32'(ccff_tail), 32'(0));
    @(negedge prog_clk);
    pReset = 1'b1;
  endtask

  // Monitor: one expected record per stimulus cycle, compared after the edge.
  initial begin
    forever begin
      @(posedge prog_clk);
      #1;
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("sb_out", 32'(out), 32'(me.out));
        chk("sb_full", 32'(cfg_full), 32'(me.full));
        chk("sb_err", 32'(cfg_err), 32'(me.err));
        chk("sb_tail", 32'(ccff_tail), 32'(me.tail));
      end
    end
  end

  initial begin
    logic first_bit;
    chain_m  = '0;
    active_m = '0;
    cnt_m    = 0;

    do_reset();

    // ch1 leaf 13, ch0 leaf 5
    load(8'b0010_1010, 8);
    settle();
    chk("t2_full_pre", 32'(cfg_full), 32'(1));
    step(1'b0, 1'b0, 1'b1, 14'h0020);
    settle();
    chk("t2_full_post", 32'(cfg_full), 32'(0));
    idle(14'h0020);
    settle();
    chk("t2_out_a", 32'(out), 32'(2'b01));
    idle(14'h2000);
    settle();
    chk("t2_out_b", 32'(out), 32'(2'b10));

    // Premature commit
    load(8'b1100_1100, 5);
    step(1'b0, 1'b0, 1'b1, 14'h2000);
    settle();
    chk("t3_err", 32'(cfg_err), 32'(1));
    chk("t3_out", 32'(out), 32'(2'b10));
    idle(14'h2000);
    settle();
    chk("t3_err_clr", 32'(cfg_err), 32'(0));
    load(8'b1100_1100, 3);
    settle();
    chk("t3_full", 32'(cfg_full), 32'(1));
    step(1'b0, 1'b0, 1'b1, '0);

    // ch0 select 0001 picks a constant leaf
    load({4'($urandom), 4'b0001}, 8);
    step(1'b0, 1'b0, 1'b1, '0);
    idle('0);
    idle('0);
    settle();
    chk("t4_out0_const", 32'(out[0]), 32'(1));

    // Pass-through and commit with simultaneous shift
    first_bit = 1'($urandom);
    step(1'b1, first_bit, 1'b0, N_IN'($urandom));
    load(TOT'($urandom), 7);
    settle();
    chk("t5_tail_first", 32'(ccff_tail), 32'(first_bit));
    load(TOT'($urandom), 1);
    step(1'b1, 1'b1, 1'b1, N_IN'($urandom));
    settle();
    chk("t5_full_after", 32'(cfg_full), 32'(0));
    load(TOT'($urandom), TOT - 1);
    settle();
    chk("t5_full_again", 32'(cfg_full), 32'(1));

    // Reset mid-load
    step(1'b0, 1'b0, 1'b1, N_IN'($urandom));
    load(TOT'($urandom), 4);
    do_reset();
    load(TOT'($urandom), TOT - 1);
    settle();
    chk("t6_cnt_cleared", 32'(cfg_full), 32'(0));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        settle();
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0, N_IN'($urandom));
      end
    end
    idle('0);

    repeat (4) @(posedge prog_clk);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expected records left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
